// File: rtl/aes_sbox_share_sched.sv
// aes_sbox_share_sched: shares NUM_SBOX S-box lanes between SubBytes and key-schedule SubWord jobs,
// one pass of NUM_SBOX bytes per granted cycle, results returned on a held valid/ready handshake.
module aes_sbox_share_sched #(
    parameter int NUM_SBOX    = 4,
    parameter bit KS_PRIORITY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sb_req_valid,
    output logic         sb_req_ready,
    input  logic         sb_enc_dec,
    input  logic [127:0] sb_state_in,
    output logic         sb_resp_valid,
    input  logic         sb_resp_ready,
    output logic [127:0] sb_state_out,
    input  logic         kw_req_valid,
    output logic         kw_req_ready,
    input  logic [31:0]  kw_word_in,
    output logic         kw_resp_valid,
    input  logic         kw_resp_ready,
    output logic [31:0]  kw_word_out,
    output logic         busy
);
    localparam int LW = NUM_SBOX * 8;
    localparam logic [4:0] SB_P = 5'(16 / NUM_SBOX);
    localparam logic [4:0] KW_P = 5'((NUM_SBOX >= 4) ? 1 : 4 / NUM_SBOX);
    localparam logic [127:0] LMASK = (128'd1 << LW) - 128'd1;
    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} st_t;
    st_t sb_st, sb_st_n, kw_st, kw_st_n;
    logic [4:0] sb_cnt, kw_cnt;
    logic [127:0] sb_work, sb_nxt, lane_w;
    logic [31:0] kw_work, kw_nxt;
    logic sb_enc, last_kw, sb_want, kw_want, g_sb, g_kw, lane_enc;
    logic [LW-1:0] lane_in, lane_out;
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, p;
        r = 8'h00;
        p = a;
        for (int i = 0; i < 8; i++) begin
            r = b[i] ? r ^ p : r;
            p = xt(p);
        end
        return r;
    endfunction
    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction
    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction
    function automatic logic [7:0] sbox(input logic [7:0] x, input logic enc);
        logic [7:0] v, s;
        v = gf_inv(x);
        s = v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
        return enc ? s : gf_inv(rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05);
    endfunction
    always_comb begin
        sb_want  = (sb_st == ACTIVE) && (sb_cnt < SB_P);
        kw_want  = (kw_st == ACTIVE) && (kw_cnt < KW_P);
        g_kw     = kw_want & (KS_PRIORITY | ~sb_want | ~last_kw);
        g_sb     = sb_want & ~g_kw;
        lane_enc = g_kw | (g_sb & sb_enc);
        lane_in  = g_kw ? LW'({96'b0, kw_work} >> (32'(kw_cnt) * LW)) :
                   g_sb ? LW'(sb_work >> (32'(sb_cnt) * LW)) : '0;
        lane_out = '0;
        for (int k = 0; k < NUM_SBOX; k++)
            lane_out[8*k +: 8] = sbox(lane_in[8*k +: 8], lane_enc);
        lane_w   = 128'(lane_out);
        sb_nxt   = (sb_work & ~(LMASK << (32'(sb_cnt) * LW))) | (lane_w << (32'(sb_cnt) * LW));
        kw_nxt   = (kw_work & ~32'(LMASK << (32'(kw_cnt) * LW))) | 32'(lane_w << (32'(kw_cnt) * LW));
        sb_st_n  = (sb_st == IDLE && sb_req_valid) ? ACTIVE :
                   (sb_st == ACTIVE && sb_cnt == SB_P) ? RESP :
                   (sb_st == RESP && sb_resp_ready) ? IDLE : sb_st;
        kw_st_n  = (kw_st == IDLE && kw_req_valid) ? ACTIVE :
                   (kw_st == ACTIVE && kw_cnt == KW_P) ? RESP :
                   (kw_st == RESP && kw_resp_ready) ? IDLE : kw_st;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_st        <= IDLE;
            kw_st        <= IDLE;
            sb_cnt       <= '0;
            kw_cnt       <= '0;
            sb_work      <= '0;
            kw_work      <= '0;
            sb_enc       <= 1'b0;
            last_kw      <= 1'b0;
            sb_state_out <= '0;
            kw_word_out  <= '0;
        end else begin
            sb_st <= sb_st_n;
            kw_st <= kw_st_n;
            if (sb_st == IDLE && sb_req_valid) begin
                sb_work <= sb_state_in;
                sb_enc  <= sb_enc_dec;
                sb_cnt  <= '0;
            end else if (g_sb) begin
                sb_work <= sb_nxt;
                sb_cnt  <= sb_cnt + 5'd1;
            end
            if (kw_st == IDLE && kw_req_valid) begin
                kw_work <= kw_word_in;
                kw_cnt  <= '0;
            end else if (g_kw) begin
                kw_work <= kw_nxt;
                kw_cnt  <= kw_cnt + 5'd1;
            end
            if (sb_st == ACTIVE && sb_cnt == SB_P)
                sb_state_out <= sb_work;
            if (kw_st == ACTIVE && kw_cnt == KW_P)
                kw_word_out <= kw_work;
            if (sb_want && kw_want)
                last_kw <= g_kw;
        end
    end
    // ready is gated by rst_n so every output reads 0 while reset is held
    assign sb_req_ready  = rst_n && (sb_st == IDLE);
    assign kw_req_ready  = rst_n && (kw_st == IDLE);
    assign sb_resp_valid = (sb_st == RESP);
    assign kw_resp_valid = (kw_st == RESP);
    assign busy          = (sb_st == ACTIVE) || (kw_st == ACTIVE);
endmodule
